stereo_frame_ctrl: RTL and testbench

STEREO_FRAME_CTRL -- requirements
Module: stereo_frame_ctrl

---
 rtl/stereo_pkg.sv | 20 ++
 rtl/cdc_edge_sync.sv | 22 ++
 rtl/stereo_frame_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_stereo_frame_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// Shared encodings and widths for the stereo frame controller.
package stereo_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned FCNT_W  = 16;
  localparam int unsigned STATE_W = 3;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [FCNT_W-1:0]  fcnt_t;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FSYNC     = 3'd1;
  localparam state_t ST_WAIT_SYNC = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_DRAIN     = 3'd4;
  localparam state_t ST_DONE      = 3'd5;
  localparam state_t ST_ERR       = 3'd6;

endpackage

// File: rtl/cdc_edge_sync.sv
// Two-flop synchronizer for a slow asynchronous level, followed by a rising-edge detector.
module cdc_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  // [0],[1] form the synchronizer; [2] is the edge-detect history.
  logic [2:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_async};
    end
  end

  assign o_rise = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/stereo_frame_ctrl.sv
// Frame sequencer: CPU start/abort handshake, DMA frame sync, pixel advance strobes with
// coordinates and frame markers, drain, completion counting and sync-timeout detection.
module stereo_frame_ctrl
  import stereo_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 640,
  parameter int unsigned IMAGE_HEIGHT = 480,
  parameter int unsigned DRAIN_SLOTS  = 4,
  parameter int unsigned SYNC_TIMEOUT = 1 << 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pixel_en,
  input  logic               cpu_start,
  input  logic               cpu_abort,
  input  logic               in_stream_ok,
  input  logic               wr_fifo_full,
  output logic               mm2s_fsyn,
  output logic               en_out,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  output logic [COORD_W-1:0] col_cnt,
  output logic [COORD_W-1:0] row_cnt,
  output logic               busy,
  output logic               frame_done,
  output logic               stall_err,
  output logic [FCNT_W-1:0]  frame_cnt
);

  localparam int unsigned TO_W = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned DR_W = $clog2(DRAIN_SLOTS + 1);

  localparam coord_t           LAST_COL  = coord_t'(IMAGE_WIDTH - 1);
  localparam coord_t           LAST_ROW  = coord_t'(IMAGE_HEIGHT - 1);
  localparam coord_t           COORD_ONE = coord_t'(1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(SYNC_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
  localparam logic [DR_W-1:0]  DR_LAST   = DR_W'(DRAIN_SLOTS - 1);
  localparam logic [DR_W-1:0]  DR_ONE    = DR_W'(1);

  logic w_start;
  logic w_abort;
  logic w_adv;
  logic w_px_first;
  logic w_px_last_col;
  logic w_px_last;
  logic w_timeout;
  state_t w_state_nxt;

  state_t          r_state;
  coord_t          r_px_col;
  coord_t          r_px_row;
  coord_t          r_col;
  coord_t          r_row;
  logic            r_en;
  logic            r_sof;
  logic            r_eol;
  logic            r_eof;
  logic [TO_W-1:0] r_to_cnt;
  logic [DR_W-1:0] r_dr_cnt;
  logic            r_stall;
  fcnt_t           r_fcnt;

  cdc_edge_sync u_start_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (cpu_start),
    .o_rise  (w_start)
  );

  cdc_edge_sync u_abort_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (cpu_abort),
    .o_rise  (w_abort)
  );

  always_comb begin
    // A skipped slot simply produces no advance; nothing is queued for later.
    w_adv         = (r_state == ST_RUN) && pixel_en && in_stream_ok && !wr_fifo_full;
    w_px_first    = (r_px_col == '0) && (r_px_row == '0);
    w_px_last_col = (r_px_col == LAST_COL);
    w_px_last     = w_adv && w_px_last_col && (r_px_row == LAST_ROW);
    w_timeout     = (r_state == ST_WAIT_SYNC) && !in_stream_ok && (r_to_cnt == TO_LAST);

    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      if (w_start) w_state_nxt = ST_FSYNC;
        ST_FSYNC:     w_state_nxt = ST_WAIT_SYNC;
        ST_WAIT_SYNC: begin
          if (in_stream_ok)   w_state_nxt = ST_RUN;
          else if (w_timeout) w_state_nxt = ST_ERR;
        end
        ST_RUN:       if (w_px_last) w_state_nxt = ST_DRAIN;
        ST_DRAIN:     if (pixel_en && (r_dr_cnt == DR_LAST)) w_state_nxt = ST_DONE;
        ST_DONE:      w_state_nxt = ST_IDLE;
        ST_ERR:       w_state_nxt = ST_ERR;
        default:      w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_px_col <= '0;
      r_px_row <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_en     <= 1'b0;
      r_sof    <= 1'b0;
      r_eol    <= 1'b0;
      r_eof    <= 1'b0;
      r_to_cnt <= '0;
      r_dr_cnt <= '0;
      r_stall  <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_state <= w_state_nxt;

      r_en  <= w_adv && !w_abort;
      r_sof <= w_adv && !w_abort && w_px_first;
      r_eol <= w_adv && !w_abort && w_px_last_col;
      r_eof <= w_px_last && !w_abort;

      // Output coordinates name the advanced pixel and read zero outside RUN.
      if (w_adv && !w_abort) begin
        r_col <= r_px_col;
        r_row <= r_px_row;
      end else if (w_abort || (r_state != ST_RUN)) begin
        r_col <= '0;
        r_row <= '0;
      end

      if (w_abort || (r_state == ST_IDLE)) begin
        r_px_col <= '0;
        r_px_row <= '0;
      end else if (w_adv) begin
        if (w_px_last_col) begin
          r_px_col <= '0;
          r_px_row <= (r_px_row == LAST_ROW) ? '0 : r_px_row + COORD_ONE;
        end else begin
          r_px_col <= r_px_col + COORD_ONE;
        end
      end

      if ((r_state == ST_WAIT_SYNC) && !in_stream_ok) begin
        r_to_cnt <= r_to_cnt + TO_ONE;
      end else begin
        r_to_cnt <= '0;
      end

      if (r_state != ST_DRAIN) begin
        r_dr_cnt <= '0;
      end else if (pixel_en) begin
        r_dr_cnt <= r_dr_cnt + DR_ONE;
      end

      if (!w_abort && w_timeout) begin
        r_stall <= 1'b1;
      end else if (!w_abort && (r_state == ST_IDLE) && w_start) begin
        r_stall <= 1'b0;
      end

      if (!w_abort && (r_state == ST_DONE)) begin
        r_fcnt <= r_fcnt + fcnt_t'(1);
      end
    end
  end

  assign mm2s_fsyn  = (r_state == ST_FSYNC);
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE) && !w_abort;
  assign en_out     = r_en;
  assign sof        = r_sof;
  assign eol        = r_eol;
  assign eof        = r_eof;
  assign col_cnt    = r_col;
  assign row_cnt    = r_row;
  assign stall_err  = r_stall;
  assign frame_cnt  = r_fcnt;

endmodule

// File: tb/tb_stereo_frame_ctrl.sv
// Scoreboard bench for stereo_frame_ctrl on a 4x2 image with a pixel slot every 8th clock.
module tb_stereo_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DS = 2;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pixel_en = 1'b0;
  logic        cpu_start = 1'b0;
  logic        cpu_abort = 1'b0;
  logic        in_stream_ok = 1'b0;
  logic        wr_fifo_full = 1'b0;
  logic        mm2s_fsyn;
  logic        en_out;
  logic        sof;
  logic        eol;
  logic        eof;
  logic [9:0]  col_cnt;
  logic [9:0]  row_cnt;
  logic        busy;
  logic        frame_done;
  logic        stall_err;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  stereo_frame_ctrl #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .DRAIN_SLOTS  (DS),
    .SYNC_TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_en     (pixel_en),
    .cpu_start    (cpu_start),
    .cpu_abort    (cpu_abort),
    .in_stream_ok (in_stream_ok),
    .wr_fifo_full (wr_fifo_full),
    .mm2s_fsyn    (mm2s_fsyn),
    .en_out       (en_out),
    .sof          (sof),
    .eol          (eol),
    .eof          (eof),
    .col_cnt      (col_cnt),
    .row_cnt      (row_cnt),
    .busy         (busy),
    .frame_done   (frame_done),
    .stall_err    (stall_err),
    .frame_cnt    (frame_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0;
  int fsyn_cnt = 0;
  int done_cnt = 0;
  int slot_cnt = 0;
  int eof_cyc = 0;
  int done_cyc = 0;
  int fsyn_cyc = 0;
  int stall_cyc = -1;
  logic stall_prev = 1'b0;

  // Expected pixel: {col[9:0], row[9:0], sof, eol, eof}
  logic [22:0] pix_q[$];
  int          done_q[$];

  function automatic logic [22:0] pix(input int c, input int r);
    return {10'(c), 10'(r), (c == 0) && (r == 0), (c == W - 1), (c == W - 1) && (r == H - 1)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_pixels(input int n);
    for (int i = 0; i < n; i++) pix_q.push_back(pix(i % W, i / W));
  endtask

  // Pixel slot generator: one pixel_en clock in every eight.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      pixel_en = (ph == 0);
      if (ph == 0) slot_cnt++;
      ph = (ph + 1) % 8;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents en_out or frame_done.
  initial begin
    forever begin
      logic [22:0] e;
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (en_out) begin
          en_cnt++;
          if (eof) eof_cyc = cyc;
          checks++;
          if (pix_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_en_out: got col=%0d row=%0d expected no pulse",
                     col_cnt, row_cnt);
          end else begin
            e = pix_q.pop_front();
            if ({col_cnt, row_cnt, sof, eol, eof} !== e) begin
              failures++;
              $display("FAIL pixel: got col=%0d row=%0d sof=%b eol=%b eof=%b expected col=%0d row=%0d sof=%b eol=%b eof=%b",
                       col_cnt, row_cnt, sof, eol, eof, e[22:13], e[12:3], e[2], e[1], e[0]);
            end
          end
        end
        if (frame_done) begin
          done_cnt++;
          done_cyc = cyc;
          if (done_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame_done: got frame_cnt=%0d expected no pulse", frame_cnt);
          end else begin
            chk("frame_cnt_at_done", int'(frame_cnt), done_q.pop_front());
          end
        end
        if (mm2s_fsyn) begin
          fsyn_cnt++;
          fsyn_cyc = cyc;
        end
        if (stall_err && !stall_prev) stall_cyc = cyc;
        stall_prev = stall_err;
      end
    end
  end

  task automatic pulse_start();
    cpu_start = 1'b1;
    repeat (5) @(posedge clk);
    #1 cpu_start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_abort();
    cpu_abort = 1'b1;
    repeat (5) @(posedge clk);
    #1 cpu_abort = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== lvl) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got busy=%b expected %b", name, busy, lvl);
    end
  endtask

  task automatic wait_en(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (en_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (en_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got en_count=%0d expected %0d", name, en_cnt, target);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, fs0, fc0, dc0, s0, n;

    // Reset state
    #1 rst_n = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_en_out", en_out, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_col_row", {col_cnt, row_cnt}, 0);
    chk("rst_flags", {mm2s_fsyn, sof, eol, eof, frame_done, stall_err}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Normal frame
    in_stream_ok = 1'b1;
    e0 = en_cnt; fs0 = fsyn_cnt;
    push_pixels(8);
    done_q.push_back(0);
    pulse_start();
    wait_busy(1'b1, 20, "t1_busy");
    wait_busy(1'b0, 400, "t1_idle");
    chk("t1_fsyn_pulses", fsyn_cnt - fs0, 1);
    chk("t1_en_pulses", en_cnt - e0, 8);
    chk("t1_pix_q_left", pix_q.size(), 0);
    chk("t1_done_q_left", done_q.size(), 0);
    chk("t1_done_delay", done_cyc - eof_cyc, 16);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_busy", busy, 0);

    // Output FIFO full for three slots mid-line
    e0 = en_cnt;
    push_pixels(8);
    done_q.push_back(1);
    pulse_start();
    wait_en(e0 + 2, 200, "t2_first");
    wr_fifo_full = 1'b1;
    s0 = slot_cnt;
    n = 0;
    while (slot_cnt < s0 + 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #2 wr_fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_skipped_slots_en", en_cnt - e0, 2);
    wait_busy(1'b0, 400, "t2_idle");
    chk("t2_en_pulses", en_cnt - e0, 8);
    chk("t2_pix_q_left", pix_q.size(), 0);
    chk("t2_frame_cnt", frame_cnt, 2);

    // Input stream never syncs
    in_stream_ok = 1'b0;
    stall_cyc = -1;
    pulse_start();
    n = 0;
    while (!stall_err && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t3_stall_set", stall_err, 1);
    chk("t3_timeout_clks", stall_cyc - fsyn_cyc, TO + 1);
    repeat (10) @(negedge clk);
    chk("t3_err_holds", busy, 1);
    pulse_abort();
    wait_busy(1'b0, 20, "t3_abort_idle");
    chk("t3_stall_sticky", stall_err, 1);
    fs0 = fsyn_cnt;
    cpu_start = 1'b1;
    n = 0;
    while (fsyn_cnt == fs0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_restart_fsyn", fsyn_cnt - fs0, 1);
    chk("t3_stall_cleared", stall_err, 0);
    cpu_start = 1'b0;
    pulse_abort();
    wait_busy(1'b0, 20, "t3_final_idle");
    chk("t3_stall_after_abort", stall_err, 0);

    // Abort at pixel (2,0)
    in_stream_ok = 1'b1;
    e0 = en_cnt; fc0 = frame_cnt; dc0 = done_cnt;
    push_pixels(3);
    pulse_start();
    wait_en(e0 + 3, 200, "t4_pixels");
    pulse_abort();
    wait_busy(1'b0, 20, "t4_idle");
    repeat (40) @(negedge clk);
    chk("t4_col_row", {col_cnt, row_cnt}, 0);
    chk("t4_frame_cnt", frame_cnt, fc0);
    chk("t4_no_done", done_cnt - dc0, 0);
    chk("t4_en_pulses", en_cnt - e0, 3);
    chk("t4_pix_q_left", pix_q.size(), 0);

    // Start edge while running is ignored
    e0 = en_cnt; fs0 = fsyn_cnt;
    push_pixels(8);
    done_q.push_back(2);
    pulse_start();
    wait_en(e0 + 2, 200, "t5_first");
    pulse_start();
    wait_busy(1'b0, 400, "t5_idle");
    chk("t5_en_pulses", en_cnt - e0, 8);
    chk("t5_fsyn_pulses", fsyn_cnt - fs0, 1);
    chk("t5_frame_cnt", frame_cnt, 3);
    chk("t5_done_q_left", done_q.size(), 0);

    // Reset at pixel (1,1)
    e0 = en_cnt;
    push_pixels(6);
    pulse_start();
    wait_en(e0 + 6, 200, "t6_pixels");
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_en_out", en_out, 0);
    chk("t6_col_row", {col_cnt, row_cnt}, 0);
    chk("t6_frame_cnt", frame_cnt, 0);
    chk("t6_flags", {mm2s_fsyn, sof, eol, eof, frame_done, stall_err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e0 = en_cnt;
    repeat (60) @(negedge clk);
    chk("t6_no_stale_en", en_cnt - e0, 0);
    chk("t6_idle_after", busy, 0);
    chk("t6_pix_q_left", pix_q.size(), 0);

    // Recovery after reset
    e0 = en_cnt;
    push_pixels(8);
    done_q.push_back(0);
    pulse_start();
    wait_busy(1'b1, 20, "t7_busy");
    wait_busy(1'b0, 400, "t7_idle");
    chk("t7_en_pulses", en_cnt - e0, 8);
    chk("t7_frame_cnt", frame_cnt, 1);
    chk("t7_done_q_left", done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
